div_arbiter: RTL and testbench

Shares one integer divider (`div_int`, unsigned `x / y` with quotient, remainder and divide-by-zero flag) among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter grants one request at a time and sequences the divider's `start`/`busy`/`valid`/`dbz` protocol. The result returns as a one-cycle response tagged with the requester index. The block sits between the requesting datapaths and a single `div_int` instance.

---
 rtl/div_arbiter_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/div_arbiter.sv | 145 ++++++++++++++
 tb/tb_div_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arbiter_pkg.sv
// Shared types and helpers for the divider arbiter.
// Holds the FSM state encoding and the id-width function.
package div_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } div_arb_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request
// at or after ptr, wrapping, as one-hot and index.
module rr_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]             req,
    input  logic [id_width(N)-1:0]   ptr,
    output logic [N-1:0]             gnt,
    output logic [id_width(N)-1:0]   gnt_id
);

    localparam int IW = id_width(N);
    localparam logic [IW:0] NW = (IW+1)'(N);

    logic [IW:0] idx;
    logic        found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (IW+1)'(i);
            if (idx >= NW) begin
                idx = idx - NW;
            end
            if (!found && req[idx[IW-1:0]]) begin
                found                = 1'b1;
                gnt[idx[IW-1:0]]     = 1'b1;
                gnt_id               = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one integer divider among NREQ requesters with
// round-robin arbitration, a watchdog and tagged responses.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_x,
    input  logic [NREQ*WIDTH-1:0]     req_y,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    output logic [id_width(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]          rsp_q,
    output logic [WIDTH-1:0]          rsp_r,
    output logic                      rsp_dbz,
    output logic                      rsp_err,
    output logic                      div_start,
    output logic [WIDTH-1:0]          div_x,
    output logic [WIDTH-1:0]          div_y,
    input  logic                      div_busy,
    input  logic                      div_valid,
    input  logic                      div_dbz,
    input  logic [WIDTH-1:0]          div_q,
    input  logic [WIDTH-1:0]          div_r
);

    localparam int IDW = id_width(NREQ);
    localparam int CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  WD_LAST = CW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);

    div_arb_state_t state_q;

    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             dbz_q;
    logic             err_q;
    logic             start_q;
    logic             valid_q;
    logic [CW-1:0]    wd_q;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_id;
    logic             done;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = (state_q == IDLE) ? gnt : '0;
    assign done      = !div_busy && (div_valid || div_dbz);
    assign ptr_d     = (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            wd_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        x_q     <= req_x[int'(gnt_id)*WIDTH +: WIDTH];
                        y_q     <= req_y[int'(gnt_id)*WIDTH +: WIDTH];
                        id_q    <= gnt_id;
                        ptr_q   <= ptr_d;
                        start_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    wd_q    <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Completion wins over a watchdog expiry in the same cycle
                    if (done) begin
                        q_q     <= div_q;
                        r_q     <= div_r;
                        dbz_q   <= div_dbz;
                        err_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end else if (wd_q == WD_LAST) begin
                        q_q     <= '0;
                        r_q     <= '0;
                        dbz_q   <= 1'b0;
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                RESP: begin
                    valid_q <= 1'b0;
                    q_q     <= '0;
                    r_q     <= '0;
                    dbz_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_id    = id_q;
    assign rsp_q     = q_q;
    assign rsp_r     = r_q;
    assign rsp_dbz   = dbz_q;
    assign rsp_err   = err_q;
    assign div_start = start_q;
    assign div_x     = x_q;
    assign div_y     = y_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: stub divider, cycle-level model
// checked every cycle, plus directed literal expectations.
module tb_div_arbiter;

    localparam int W       = 4;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int LAT     = 2;
    localparam int IW      = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_x = '0;
    logic [NREQ*W-1:0] req_y = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_q;
    logic [W-1:0]      rsp_r;
    logic              rsp_dbz;
    logic              rsp_err;
    logic              div_start;
    logic [W-1:0]      div_x;
    logic [W-1:0]      div_y;
    logic              sb_busy;
    logic              sb_valid;
    logic              sb_dbz;
    logic [W-1:0]      sb_q;
    logic [W-1:0]      sb_r;
    int                sb_cnt;
    logic              hang = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_arbiter #(
        .WIDTH   (W),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_dbz   (rsp_dbz),
        .rsp_err   (rsp_err),
        .div_start (div_start),
        .div_x     (div_x),
        .div_y     (div_y),
        .div_busy  (sb_busy),
        .div_valid (sb_valid),
        .div_dbz   (sb_dbz),
        .div_q     (sb_q),
        .div_r     (sb_r)
    );

    // Stub divider: LAT busy cycles, dbz on the edge after start, or hang.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_busy  <= 1'b0;
            sb_valid <= 1'b0;
            sb_dbz   <= 1'b0;
            sb_q     <= '0;
            sb_r     <= '0;
            sb_cnt   <= 0;
        end else begin
            sb_valid <= 1'b0;
            sb_dbz   <= 1'b0;
            if (div_start) begin
                if (hang) begin
                    sb_busy <= 1'b1;
                end else if (div_y == 0) begin
                    sb_dbz <= 1'b1;
                    sb_q   <= '0;
                    sb_r   <= '0;
                end else begin
                    sb_busy <= 1'b1;
                    sb_cnt  <= LAT - 1;
                    sb_q    <= div_x / div_y;
                    sb_r    <= div_x % div_y;
                end
            end else if (sb_busy && !hang) begin
                if (sb_cnt == 0) begin
                    sb_busy  <= 1'b0;
                    sb_valid <= 1'b1;
                end else begin
                    sb_cnt <= sb_cnt - 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Model state and observed history
    logic            pend = 1'b0;
    int              ptr_m = 0;
    int              acc_cyc = 0;
    int              due = 0;
    int              g;
    int              j;
    int              e_id;
    logic [W-1:0]    e_x, e_y, e_q, e_r;
    logic            e_dbz, e_err;
    logic [NREQ-1:0] exp_rdy;
    int              glog[$];
    int              gnt_cnt = 0;
    int              rsp_cnt = 0;
    int              last_acc = 0;
    int              last_rsp = 0;
    int              last_id = 0;
    logic [W-1:0]    last_q = '0;
    logic [W-1:0]    last_r = '0;
    logic            last_dbz = 1'b0;
    logic            last_err = 1'b0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            pend  = 1'b0;
            ptr_m = 0;
            chk("rst_outs", 32'({req_ready, rsp_valid, rsp_id, rsp_q,
                rsp_r, rsp_dbz, rsp_err, div_start, div_x, div_y}), 0);
        end else begin
            exp_rdy = '0;
            if (!pend && req_valid != 0) begin
                g = -1;
                for (int i = 0; i < NREQ; i++) begin
                    j = (ptr_m + i) % NREQ;
                    if (g < 0 && req_valid[j]) g = j;
                end
                exp_rdy[g] = 1'b1;
                ptr_m   = (g + 1) % NREQ;
                pend    = 1'b1;
                acc_cyc = cyc;
                e_id    = g;
                e_x     = req_x[g*W +: W];
                e_y     = req_y[g*W +: W];
                if (hang) begin
                    e_q = '0; e_r = '0; e_dbz = 1'b0; e_err = 1'b1;
                    due = cyc + TIMEOUT + 2;
                end else if (e_y == 0) begin
                    e_q = '0; e_r = '0; e_dbz = 1'b1; e_err = 1'b0;
                    due = cyc + 3;
                end else begin
                    e_q = e_x / e_y; e_r = e_x % e_y;
                    e_dbz = 1'b0; e_err = 1'b0;
                    due = cyc + 3 + LAT;
                end
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("div_start", 32'(div_start),
                32'(pend && cyc == acc_cyc + 1));
            if (pend && cyc > acc_cyc) begin
                chk("div_x", 32'(div_x), 32'(e_x));
                chk("div_y", 32'(div_y), 32'(e_y));
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(pend && cyc == due));
            if (pend && cyc == due) begin
                chk("rsp_id", 32'(rsp_id), 32'(e_id));
                chk("rsp_q", 32'(rsp_q), 32'(e_q));
                chk("rsp_r", 32'(rsp_r), 32'(e_r));
                chk("rsp_dbz", 32'(rsp_dbz), 32'(e_dbz));
                chk("rsp_err", 32'(rsp_err), 32'(e_err));
                pend = 1'b0;
            end
            if (req_ready != 0) begin
                for (int i = 0; i < NREQ; i++)
                    if (req_ready[i]) glog.push_back(i);
                gnt_cnt++;
                last_acc = cyc;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                last_rsp = cyc;
                last_id  = int'(rsp_id);
                last_q   = rsp_q;
                last_r   = rsp_r;
                last_dbz = rsp_dbz;
                last_err = rsp_err;
            end
        end
    end

    task automatic run(input logic [NREQ-1:0] mask, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int ng);
        int tgt;
        int k;
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) begin
                req_x[i*W +: W] = x;
                req_y[i*W +: W] = y;
            end
        end
        req_valid = mask;
        tgt = gnt_cnt + ng;
        k = 0;
        while (gnt_cnt < tgt && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        chk("grant_wait", 32'(gnt_cnt >= tgt), 1);
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic wait_rsp(input int n);
        int k;
        k = 0;
        while (rsp_cnt < n && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        chk("rsp_wait", 32'(rsp_cnt >= n), 1);
    endtask

    initial begin
        int base;
        int n0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single requester: 7/2
        run(4'b0010, 4'd7, 4'd2, 1);
        wait_rsp(1);
        chk("single_id", 32'(last_id), 1);
        chk("single_q", 32'(last_q), 3);
        chk("single_r", 32'(last_r), 1);
        chk("single_dbz", 32'(last_dbz), 0);
        chk("single_err", 32'(last_err), 0);
        chk("single_lat", 32'(last_rsp - last_acc), 3 + LAT);

        // Divide by zero
        run(4'b0001, 4'd2, 4'd0, 1);
        wait_rsp(2);
        chk("dbz_lat", 32'(last_rsp - last_acc), 3);
        chk("dbz_flag", 32'(last_dbz), 1);
        chk("dbz_q", 32'(last_q), 0);
        chk("dbz_r", 32'(last_r), 0);

        // Requester 3 alone, then 0 and 3 together: 0 wins after wrap
        run(4'b1000, 4'd9, 4'd4, 1);
        wait_rsp(3);
        chk("r3_q", 32'(last_q), 2);
        chk("r3_r", 32'(last_r), 1);
        run(4'b1001, 4'd6, 4'd3, 1);
        chk("wrap_gnt", 32'(glog[glog.size()-1]), 0);
        wait_rsp(4);
        chk("wrap_id", 32'(last_id), 0);
        run(4'b1000, 4'd5, 4'd5, 1);
        wait_rsp(5);

        // Contention: 0, 2, 3 held continuously
        base = glog.size();
        run(4'b1101, 4'd15, 4'd5, 6);
        wait_rsp(11);
        chk("cont_g0", 32'(glog[base+0]), 0);
        chk("cont_g1", 32'(glog[base+1]), 2);
        chk("cont_g2", 32'(glog[base+2]), 3);
        chk("cont_g3", 32'(glog[base+3]), 0);
        chk("cont_g4", 32'(glog[base+4]), 2);
        chk("cont_g5", 32'(glog[base+5]), 3);
        chk("cont_q", 32'(last_q), 3);
        chk("cont_r", 32'(last_r), 0);

        // Timeout with a hung divider
        hang = 1'b1;
        run(4'b0100, 4'd9, 4'd3, 1);
        wait_rsp(12);
        hang = 1'b0;
        chk("to_lat", 32'(last_rsp - last_acc), TIMEOUT + 2);
        chk("to_err", 32'(last_err), 1);
        chk("to_q", 32'(last_q), 0);
        chk("to_r", 32'(last_r), 0);
        chk("to_dbz", 32'(last_dbz), 0);
        chk("to_id", 32'(last_id), 2);

        // Reset during WAIT drops the result
        run(4'b0001, 4'd8, 4'd9, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n0 = rsp_cnt;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_norsp", 32'(rsp_cnt), 32'(n0));
        run(4'b1010, 4'd8, 4'd9, 1);
        wait_rsp(n0 + 1);
        chk("post_id", 32'(last_id), 1);
        chk("post_q", 32'(last_q), 0);
        chk("post_r", 32'(last_r), 8);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck want finish");
        $fatal(1);
    end

endmodule
